// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: default debounce/auto-repeat timing and the
// step-button FSM state encoding.
package board_io_pkg;

    localparam int unsigned DEF_SAMPLE_DIV     = 100000;
    localparam int unsigned DEF_STABLE_SAMPLES = 4;
    localparam int unsigned DEF_REPEAT_DELAY   = 500;
    localparam int unsigned DEF_REPEAT_PERIOD  = 200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_t;

    // Bits needed for a counter that runs 0..max(a,b)-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-input debouncer: two-flop synchronizer, sample history shifted on
// the shared tick, and the accepted (stable) level.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable
);

    logic [1:0]                sync;
    logic [STABLE_SAMPLES-1:0] hist;
    logic [STABLE_SAMPLES-1:0] hist_nx;
    logic                      all_hi;
    logic                      all_lo;

    // History as it will be after this tick, and whether it is unanimous.
    always_comb begin
        hist_nx = {hist[STABLE_SAMPLES-2:0], sync[1]};
        all_hi  = &hist_nx;
        all_lo  = ~|hist_nx;
    end

    // Synchronize, sample on tick, accept a new level once the history agrees.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync   <= '0;
            hist   <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick) begin
                hist <= hist_nx;
                if (all_hi && !stable) begin
                    stable <= 1'b1;
                end else if (all_lo && stable) begin
                    stable <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/switch_debounce.sv
// Slide-switch and step-button front end: N+1 debouncers on a shared sample
// tick, per-bit edge pulses, and a press/hold/auto-repeat step generator.
module switch_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned N              = 16,
    parameter int unsigned SAMPLE_DIV     = DEF_SAMPLE_DIV,
    parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
    parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD  = DEF_REPEAT_PERIOD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw_raw,
    input  logic         btn_raw,
    output logic [N-1:0] sw_stable,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         sw_changed,
    output logic         step_pulse,
    output logic         btn_held
);

    localparam int unsigned PW = cnt_width(SAMPLE_DIV, 2);
    localparam int unsigned CW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    logic [PW-1:0] presc;
    logic          tick;
    logic          tick_d;
    logic [N-1:0]  sw_prev;
    logic          btn_stable;

    btn_state_t    state;
    btn_state_t    state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          step_nx;

    assign tick = (presc == PW'(SAMPLE_DIV - 1));

    // Sample-rate prescaler: 0..SAMPLE_DIV-1, tick at terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_sw
        debounce_bit #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_sw (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .raw    (sw_raw[i]),
            .stable (sw_stable[i])
        );
    end

    debounce_bit #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (btn_raw),
        .stable (btn_stable)
    );

    // Per-bit edge pulses, one cycle after the debounced level changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_prev <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= sw_stable & ~sw_prev;
            sw_fall <= ~sw_stable & sw_prev;
            sw_prev <= sw_stable;
        end
    end

    assign sw_changed = |(sw_rise | sw_fall);
    assign btn_held   = btn_stable;

    // Button FSM registers. The FSM counts the tick delayed by one cycle so a
    // debounced release landing on a tick is already visible when a repeat
    // interval expires, giving release priority over the expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            step_pulse <= 1'b0;
            tick_d     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            step_pulse <= step_nx;
            tick_d     <= tick;
        end
    end

    // Button FSM next state, hold counter and step strobe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step_nx  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (btn_stable) begin
                    state_nx = ST_PRESS;
                    step_nx  = 1'b1;
                end
            end
            ST_PRESS: begin
                if (!btn_stable) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end
            end
            ST_HOLD: begin
                if (!btn_stable) begin
                    state_nx = ST_IDLE;
                end else if (tick_d) begin
                    if (cnt == CW'(REPEAT_DELAY - 1)) begin
                        state_nx = ST_REPEAT;
                        cnt_nx   = '0;
                        step_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (!btn_stable) begin
                    state_nx = ST_IDLE;
                end else if (tick_d) begin
                    if (cnt == CW'(REPEAT_PERIOD - 1)) begin
                        cnt_nx  = '0;
                        step_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with a fast sample tick. A behavioural model
// derives every output from sample run-lengths and press timing; literal
// checks pin the key scenarios.
module tb_switch_debounce;

    localparam int unsigned N      = 16;
    localparam int unsigned DIV    = 4;
    localparam int unsigned STABLE = 4;
    localparam int unsigned DELAY  = 3;
    localparam int unsigned PERIOD = 2;
    localparam int unsigned NCH    = N + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw_raw;
    logic         btn_raw;
    logic [N-1:0] sw_stable, sw_rise, sw_fall;
    logic         sw_changed, step_pulse, btn_held;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    switch_debounce #(
        .N              (N),
        .SAMPLE_DIV     (DIV),
        .STABLE_SAMPLES (STABLE),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed),
        .step_pulse (step_pulse),
        .btn_held   (btn_held)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each input is seen two cycles late; one sample every DIV cycles after
    // reset; a level is accepted after STABLE equal samples in a row. A step
    // is due one cycle after the press is accepted, then DIV*DELAY cycles
    // later, then every DIV*PERIOD cycles, while the press is still accepted.
    int unsigned  r;
    logic [NCH-1:0] raw_p1, raw_p2, st_m, st_1, st_2;
    logic         run_val [NCH];
    int unsigned  run_len [NCH];
    int unsigned  press_r;
    logic [N-1:0] e_stable, e_rise, e_fall;
    logic         e_changed, e_step, e_held;
    bit           mvalid = 0;

    always @(posedge clk) begin
        logic [NCH-1:0] raw_now, samp;
        int unsigned d;
        raw_now = {btn_raw, sw_raw};
        if (!rst_n) begin
            r = 0; raw_p1 = '0; raw_p2 = '0;
            st_m = '0; st_1 = '0; st_2 = '0; press_r = 0;
            for (int i = 0; i < NCH; i++) begin
                run_val[i] = 1'b0;
                run_len[i] = STABLE;
            end
            e_step = 1'b0;
        end else begin
            r++;
            samp   = raw_p2;
            raw_p2 = raw_p1;
            raw_p1 = raw_now;
            st_2 = st_1;
            st_1 = st_m;
            d = r - press_r - 1;
            e_step = st_1[N] && ((d == 0) ||
                     (d >= DIV*DELAY && ((d - DIV*DELAY) % (DIV*PERIOD)) == 0));
            if (r % DIV == 0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (samp[i] == run_val[i]) run_len[i]++;
                    else begin run_val[i] = samp[i]; run_len[i] = 1; end
                    if (run_len[i] >= STABLE && run_val[i] != st_m[i]) st_m[i] = run_val[i];
                end
            end
            if (st_m[N] && !st_1[N]) press_r = r;
        end
        e_stable  = st_m[N-1:0];
        e_held    = st_m[N];
        e_rise    = st_1[N-1:0] & ~st_2[N-1:0];
        e_fall    = ~st_1[N-1:0] & st_2[N-1:0];
        e_changed = |(e_rise | e_fall);
        mvalid    = 1;
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (mvalid) begin
            expect_eq("sw_stable",  32'(sw_stable),  32'(e_stable));
            expect_eq("sw_rise",    32'(sw_rise),    32'(e_rise));
            expect_eq("sw_fall",    32'(sw_fall),    32'(e_fall));
            expect_eq("sw_changed", 32'(sw_changed), 32'(e_changed));
            expect_eq("step_pulse", 32'(step_pulse), 32'(e_step));
            expect_eq("btn_held",   32'(btn_held),   32'(e_held));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int unsigned lat, bad, np;
        bit got;
        rst_n = 1'b0; sw_raw = '0; btn_raw = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("reset_outputs_zero",
                  32'({sw_stable, sw_rise, sw_fall, sw_changed, step_pulse, btn_held} != 0), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Clean change 0x0000 -> 0x0005.
        sw_raw = 16'h0005;
        got = 0; lat = 0;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (sw_rise != 0) begin got = 1; lat = k; end
        end
        expect_eq("rise_seen", 32'(got), 1);
        expect_eq("rise_latency_le19", 32'(lat <= 19), 1);
        expect_eq("rise_value", 32'(sw_rise), 32'h0005);
        expect_eq("stable_value", 32'(sw_stable), 32'h0005);
        expect_eq("changed_on_rise", 32'(sw_changed), 1);
        @(negedge clk);
        expect_eq("rise_one_cycle", 32'(sw_rise), 0);
        expect_eq("changed_one_cycle", 32'(sw_changed), 0);
        repeat (10) @(negedge clk);

        // 8-cycle glitch on bit 3 must be ignored.
        bad = 0;
        sw_raw = 16'h000D;
        for (int k = 0; k < 38; k++) begin
            if (k == 8) sw_raw = 16'h0005;
            @(negedge clk);
            if (sw_stable != 16'h0005 || sw_rise != 0 || sw_fall != 0) bad++;
        end
        expect_eq("glitch_ignored", bad, 0);

        // Several bits change together: independent pulses in one cycle.
        sw_raw = 16'h00A0;
        got = 0;
        for (int k = 1; k <= 30 && !got; k++) begin
            @(negedge clk);
            if (sw_changed) got = 1;
        end
        expect_eq("multi_seen", 32'(got), 1);
        expect_eq("multi_rise", 32'(sw_rise), 32'h00A0);
        expect_eq("multi_fall", 32'(sw_fall), 32'h0005);
        repeat (10) @(negedge clk);

        // Button held 40 cycles: 10 samples high, press accepted for 10 ticks
        // -> pulses at d = 0, 12, 20, 28, 36 cycles after acceptance.
        np = 0;
        btn_raw = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k == 40) btn_raw = 1'b0;
            @(negedge clk);
            if (step_pulse) np++;
        end
        expect_eq("hold_pulses", np, 5);

        // 20-cycle tap: accepted for 5 ticks, which outlasts the 3-tick repeat
        // delay, so the entry pulse is followed by a single repeat pulse.
        np = 0;
        btn_raw = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (k == 20) btn_raw = 1'b0;
            @(negedge clk);
            if (step_pulse) np++;
        end
        expect_eq("tap_pulses", np, 2);

        // Reach auto-repeat, then reset with button and all switches high.
        sw_raw = 16'hFFFF;
        btn_raw = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_eq("midrun_reset_zero",
                      32'({sw_stable, sw_rise, sw_fall, sw_changed, step_pulse, btn_held} != 0), 0);
        end
        rst_n = 1'b1;
        np = 0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (step_pulse) np++;
            if (k == 16) expect_eq("rise_before_accept", 32'(sw_rise), 0);
            if (k == 17) expect_eq("rise_after_reset", 32'(sw_rise), 32'hFFFF);
            if (k == 18) expect_eq("rise_after_reset_once", 32'(sw_rise), 0);
        end
        expect_eq("fresh_pulse_after_reset", np, 1);
        btn_raw = 1'b0;
        sw_raw = '0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
